apu_reg_if: RTL and testbench
=============================

Name: apu_reg_if

Overview:
- CPU-side register front end for the two APU pulse channels; the writer end of the register interface that the square channels consume.
- Decodes CPU bus writes to $4000-$4007 and $4015 and holds the per-channel register bytes driven into each square channel.
- Owns the length counters: loads on $4003/$4007, decrements on half-frame ticks, reports status on $4015 reads.
- Emits one-cycle side-effect strobes: phase/envelope restart and sweep reload.

Parameters:
- LEN_W, 8, length counter width; must hold 254.
- UNMAPPED_RD, 8'h00, value returned on reads of any address other than $4015.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  5  register offset from $4000 (0x00-0x17).
- cpu_we  in  1  write strobe, one cycle per write.
- cpu_wdata  in  8  write data.
- cpu_re  in  1  read strobe.
- cpu_rdata  out  8  read data, valid with cpu_rvalid.
- cpu_rvalid  out  1  one-cycle read-data-valid pulse.
- half_frame  in  1  one-cycle half-frame tick from the frame sequencer.
- p1_r0, p1_r1, p1_r2, p1_r3  out  8 each  pulse 1 register bytes ($4000-$4003).
- p2_r0, p2_r1, p2_r2, p2_r3  out  8 each  pulse 2 register bytes ($4004-$4007).
- p1_restart, p2_restart  out  1  one-cycle pulse after a $4003/$4007 write.
- p1_sweep_reload, p2_sweep_reload  out  1  one-cycle pulse after a $4001/$4005 write.
- p1_active, p2_active  out  1  length counter nonzero.

Behaviour:
- Reset (async, rst_n=0): all register bytes, length counters and enable bits = 0; all strobes, cpu_rvalid and cpu_rdata = 0. Reset asserted mid-operation aborts any pending strobe or read.
- Write, cpu_we=1: the addressed byte updates on that clock edge and is visible on its output the next cycle.
  - Offsets 0x00-0x03 map to p1_r0..r3; 0x04-0x07 map to p2_r0..r3; 0x15 maps to the enable register.
  - All other offsets: write ignored.
- Strobes: registered, high exactly the cycle after the qualifying write, for one cycle only. Back-to-back writes produce back-to-back pulses.
- Enable register ($4015 write): bit0 = pulse 1 enable, bit1 = pulse 2 enable.
  - Clearing an enable bit zeroes that length counter on the same edge.
  - While disabled, the length counter stays 0 and cannot load.
- Length load on a $4003/$4007 write, when the channel is enabled: counter = LEN[wdata[7:3]].
  - LEN[0..31] = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
  - The restart strobe fires whether or not the channel is enabled.
- Decrement on half_frame=1: a counter decrements by 1 if it is nonzero and its halt bit (r0[5]) is 0.
  - Saturates at 0; never wraps.
  - The halt value used is the register value before any same-cycle write.
- Simultaneous events:
  - Length load and half_frame in the same cycle: load wins, no decrement.
  - $4015 disable and length load in the same cycle: disable wins, counter = 0.
- p1_active / p2_active = (counter != 0), derived combinationally from the registered counter.
- Read, cpu_re=1: cpu_rvalid pulses the next cycle.
  - cpu_rdata for $4015 = {6'b0, p2_active, p1_active}, sampled before any same-cycle write or decrement.
  - cpu_rdata for any other offset = UNMAPPED_RD.
  - cpu_rdata holds its value until the next read.
  - Reads have no side effects.
- cpu_we and cpu_re may be asserted in the same cycle; both are honoured.

Test Plan:
- Reset with all outputs checked at 0. Write $4015=0x03, then $4003=0x08 -> p1_r3=0x08 next cycle; p1_restart high for exactly 1 cycle; length=254; p1_active=1; $4015 read returns 0x01.
- $4000=0x00, $4007=0x18 with pulse 2 enabled -> length 2. Two half_frame ticks -> p2_active falls after the second tick. A third tick leaves the counter at 0 (no wrap).
- $4000=0x20 (halt), load p1 length 10 -> 5 half_frame ticks leave length 10. Write $4000=0x00, then one tick -> 9.
- Write $4015=0x02 while p1 length=254 -> p1_active=0 next cycle. A subsequent $4003 write -> p1_restart pulses, but p1_active stays 0.
- Same cycle: $4003=0x08 write plus half_frame -> length 254, not 253. Same cycle: $4015 read plus half_frame taking p1 from 1 to 0 -> read returns 0x01.
- $4001=0x88 write -> p1_sweep_reload 1-cycle pulse. Read of $4009 -> 0x00 with cpu_rvalid. Pull rst_n low mid-sequence -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/apu_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : apu_reg_if
// Brief    : CPU register front end for the two APU pulse channels: register
//            bytes, length counters, status read and side-effect strobes.
// Revision : 1.0  initial release
// ============================================================================
module apu_reg_if #(
  parameter int         LEN_W       = 8,
  parameter logic [7:0] UNMAPPED_RD = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] cpu_addr,
  input  logic       cpu_we,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_re,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  input  logic       half_frame,
  output logic [7:0] p1_r0,
  output logic [7:0] p1_r1,
  output logic [7:0] p1_r2,
  output logic [7:0] p1_r3,
  output logic [7:0] p2_r0,
  output logic [7:0] p2_r1,
  output logic [7:0] p2_r2,
  output logic [7:0] p2_r3,
  output logic       p1_restart,
  output logic       p2_restart,
  output logic       p1_sweep_reload,
  output logic       p2_sweep_reload,
  output logic       p1_active,
  output logic       p2_active
);

  localparam logic [4:0] C_ADDR_P1_SWEEP = 5'h01;
  localparam logic [4:0] C_ADDR_P1_LEN   = 5'h03;
  localparam logic [4:0] C_ADDR_P2_SWEEP = 5'h05;
  localparam logic [4:0] C_ADDR_P2_LEN   = 5'h07;
  localparam logic [4:0] C_ADDR_STATUS   = 5'h15;

  logic [3:0][7:0]  r_p1;
  logic [3:0][7:0]  r_p2;
  logic [1:0]       r_en;
  logic [LEN_W-1:0] r_len1;
  logic [LEN_W-1:0] r_len2;
  logic             r_p1_restart;
  logic             r_p2_restart;
  logic             r_p1_sweep;
  logic             r_p2_sweep;
  logic [7:0]       r_rdata;
  logic             r_rvalid;

  logic             w_wr_p1;
  logic             w_wr_p2;
  logic             w_wr_en;
  logic             w_load1;
  logic             w_load2;
  logic [1:0]       w_en_nxt;
  logic [LEN_W-1:0] w_len1_nxt;
  logic [LEN_W-1:0] w_len2_nxt;
  logic [7:0]       w_status;

  function automatic logic [LEN_W-1:0] len_lut(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;  5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;  5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;  5'd11: v = 8'd10;
      5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;  5'd15: v = 8'd14;
      5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;  5'd19: v = 8'd18;
      5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;  5'd23: v = 8'd22;
      5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;  5'd27: v = 8'd26;
      5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;  default: v = 8'd30;
    endcase
    return LEN_W'(v);
  endfunction

  // Priority: disable (or still disabled) clears, then load, then halt-gated decrement.
  function automatic logic [LEN_W-1:0] len_next(
    input logic [LEN_W-1:0] cur,
    input logic             en,
    input logic             load,
    input logic [4:0]       idx,
    input logic             halt,
    input logic             tick
  );
    if (!en)
      return '0;
    else if (load)
      return len_lut(idx);
    else if (tick && !halt && (cur != '0))
      return cur - LEN_W'(1);
    else
      return cur;
  endfunction

  assign w_wr_p1  = cpu_we && (cpu_addr[4:2] == 3'b000);
  assign w_wr_p2  = cpu_we && (cpu_addr[4:2] == 3'b001);
  assign w_wr_en  = cpu_we && (cpu_addr == C_ADDR_STATUS);
  assign w_load1  = cpu_we && (cpu_addr == C_ADDR_P1_LEN);
  assign w_load2  = cpu_we && (cpu_addr == C_ADDR_P2_LEN);
  assign w_en_nxt = w_wr_en ? cpu_wdata[1:0] : r_en;

  // Halt bits come from the registered r0, so a same-cycle r0 write does not affect this tick.
  assign w_len1_nxt = len_next(r_len1, w_en_nxt[0], w_load1, cpu_wdata[7:3], r_p1[0][5], half_frame);
  assign w_len2_nxt = len_next(r_len2, w_en_nxt[1], w_load2, cpu_wdata[7:3], r_p2[0][5], half_frame);

  assign p1_active = (r_len1 != '0);
  assign p2_active = (r_len2 != '0);
  assign w_status  = {6'b0, p2_active, p1_active};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1         <= '0;
      r_p2         <= '0;
      r_en         <= '0;
      r_len1       <= '0;
      r_len2       <= '0;
      r_p1_restart <= 1'b0;
      r_p2_restart <= 1'b0;
      r_p1_sweep   <= 1'b0;
      r_p2_sweep   <= 1'b0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
    end else begin
      if (w_wr_p1) r_p1[cpu_addr[1:0]] <= cpu_wdata;
      if (w_wr_p2) r_p2[cpu_addr[1:0]] <= cpu_wdata;
      r_en         <= w_en_nxt;
      r_len1       <= w_len1_nxt;
      r_len2       <= w_len2_nxt;
      r_p1_restart <= w_load1;
      r_p2_restart <= w_load2;
      r_p1_sweep   <= cpu_we && (cpu_addr == C_ADDR_P1_SWEEP);
      r_p2_sweep   <= cpu_we && (cpu_addr == C_ADDR_P2_SWEEP);
      r_rvalid     <= cpu_re;
      if (cpu_re)
        r_rdata <= (cpu_addr == C_ADDR_STATUS) ? w_status : UNMAPPED_RD;
    end
  end

  assign p1_r0           = r_p1[0];
  assign p1_r1           = r_p1[1];
  assign p1_r2           = r_p1[2];
  assign p1_r3           = r_p1[3];
  assign p2_r0           = r_p2[0];
  assign p2_r1           = r_p2[1];
  assign p2_r2           = r_p2[2];
  assign p2_r3           = r_p2[3];
  assign p1_restart      = r_p1_restart;
  assign p2_restart      = r_p2_restart;
  assign p1_sweep_reload = r_p1_sweep;
  assign p2_sweep_reload = r_p2_sweep;
  assign cpu_rdata       = r_rdata;
  assign cpu_rvalid      = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_apu_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_apu_reg_if
// Brief    : Self-checking bench for apu_reg_if; read data goes through a queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_apu_reg_if;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] cpu_addr = '0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_re = 1'b0;
  logic [7:0] cpu_rdata;
  logic       cpu_rvalid;
  logic       half_frame = 1'b0;
  logic [7:0] p1_r0, p1_r1, p1_r2, p1_r3;
  logic [7:0] p2_r0, p2_r1, p2_r2, p2_r3;
  logic       p1_restart, p2_restart, p1_sweep_reload, p2_sweep_reload;
  logic       p1_active, p2_active;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb[$];

  apu_reg_if #(.LEN_W(8), .UNMAPPED_RD(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .half_frame(half_frame),
    .p1_r0(p1_r0), .p1_r1(p1_r1), .p1_r2(p1_r2), .p1_r3(p1_r3),
    .p2_r0(p2_r0), .p2_r1(p2_r1), .p2_r2(p2_r2), .p2_r3(p2_r3),
    .p1_restart(p1_restart), .p2_restart(p2_restart),
    .p1_sweep_reload(p1_sweep_reload), .p2_sweep_reload(p2_sweep_reload),
    .p1_active(p1_active), .p2_active(p2_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Read-data consumer: every rvalid pulse must match exactly one queued expectation.
  always @(negedge clk) begin
    if (cpu_rvalid) begin
      check("rd_pending", sb.size(), 1);
      if (sb.size() != 0) check("rdata", {24'b0, cpu_rdata}, {24'b0, sb.pop_front()});
    end
  end

  task automatic cyc(input logic we, input logic re, input logic [4:0] a,
                     input logic [7:0] d, input logic hf, input logic [7:0] rexp);
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d; half_frame = hf;
    if (re) sb.push_back(rexp);
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_re = 1'b0; half_frame = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b0, a, d, 1'b0, 8'h00);
  endtask

  task automatic tick();
    cyc(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 8'h00);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic drain();
    check("rvalid", cpu_rvalid, 1);
    @(negedge clk); #1;
    check("sb_empty", sb.size(), 0);
    @(posedge clk); #1;
    check("rvalid_1cyc", cpu_rvalid, 0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_p1"}, {p1_r0, p1_r1, p1_r2, p1_r3}, 32'h0);
    check({pfx, "_p2"}, {p2_r0, p2_r1, p2_r2, p2_r3}, 32'h0);
    check({pfx, "_misc"}, {17'b0, p1_restart, p2_restart, p1_sweep_reload, p2_sweep_reload,
                           p1_active, p2_active, cpu_rvalid, cpu_rdata}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Enable both, load p1 with index 1 -> 254
    wr(5'h15, 8'h03);
    wr(5'h03, 8'h08);
    check("p1_r3", p1_r3, 8'h08);
    check("p1_restart_hi", p1_restart, 1);
    check("len1_254", dut.r_len1, 254);
    check("p1_active", p1_active, 1);
    idle();
    check("p1_restart_lo", p1_restart, 0);
    cyc(1'b0, 1'b1, 5'h15, 8'h00, 1'b0, 8'h01);
    drain();
    check("rdata_hold", cpu_rdata, 8'h01);

    // p2 length 2, decrement to 0 and saturate
    wr(5'h00, 8'h00);
    wr(5'h07, 8'h18);
    check("p2_restart", p2_restart, 1);
    check("len2_2", dut.r_len2, 2);
    tick();
    check("p2_act_t1", p2_active, 1);
    tick();
    check("p2_act_t2", p2_active, 0);
    tick();
    check("len2_sat", dut.r_len2, 0);

    // Halt on p1
    wr(5'h00, 8'h20);
    wr(5'h03, 8'h00);
    check("len1_10", dut.r_len1, 10);
    repeat (5) tick();
    check("len1_halt", dut.r_len1, 10);
    wr(5'h00, 8'h00);
    tick();
    check("len1_9", dut.r_len1, 9);

    // Disable p1 while loaded; reloads blocked but restart still fires
    wr(5'h03, 8'h08);
    check("len1_reload", dut.r_len1, 254);
    wr(5'h15, 8'h02);
    check("p1_dis_active", p1_active, 0);
    wr(5'h03, 8'h08);
    check("p1_dis_restart", p1_restart, 1);
    check("p1_dis_noload", p1_active, 0);

    // Load beats half_frame
    wr(5'h15, 8'h03);
    cyc(1'b1, 1'b0, 5'h03, 8'h08, 1'b1, 8'h00);
    check("load_vs_hf", dut.r_len1, 254);
    // Status read sees counter before same-cycle decrement 1 -> 0
    wr(5'h03, 8'h18);
    tick();
    check("len1_1", dut.r_len1, 1);
    cyc(1'b0, 1'b1, 5'h15, 8'h00, 1'b1, 8'h01);
    check("p1_act_after_hf", p1_active, 0);
    drain();
    // Simultaneous read and disable write: read returns pre-write status
    wr(5'h03, 8'h08);
    cyc(1'b1, 1'b1, 5'h15, 8'h00, 1'b0, 8'h01);
    check("we_re_disable", dut.r_len1, 0);
    drain();

    // Sweep strobes, back-to-back pulses, unmapped accesses
    wr(5'h15, 8'h03);
    wr(5'h01, 8'h88);
    check("p1_r1", p1_r1, 8'h88);
    check("p1_sweep_hi", p1_sweep_reload, 1);
    idle();
    check("p1_sweep_lo", p1_sweep_reload, 0);
    wr(5'h05, 8'h11);
    check("p2_sweep_b2b0", p2_sweep_reload, 1);
    wr(5'h05, 8'h22);
    check("p2_sweep_b2b1", p2_sweep_reload, 1);
    check("p2_r1", p2_r1, 8'h22);
    wr(5'h08, 8'hFF);
    check("unmapped_wr", {p1_r0, p2_r0}, 16'h0000);
    cyc(1'b0, 1'b1, 5'h09, 8'h00, 1'b0, 8'h00);
    drain();

    // Asynchronous reset mid-operation
    wr(5'h03, 8'h08);
    cyc(1'b0, 1'b1, 5'h15, 8'h00, 1'b0, 8'h01);
    drain();
    cpu_we = 1'b1; cpu_addr = 5'h03; cpu_wdata = 8'h08;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    check("pre_rst_restart", p1_restart, 1);
    check("pre_rst_rdata", cpu_rdata, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); #1;
    check_all_zero("rst_hold");
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
